// File: rtl/trdb_reg_ctrl.sv
// ============================================================================
// Module      : trdb_reg_ctrl
// Description : Memory-mapped control/status registers for the trace encoder:
//               packet-emitter options, per-channel trace enables and
//               saturating per-channel enable-event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trdb_reg_ctrl #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CFG_W  = 2,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_req_i,
    input  logic              reg_we_i,
    input  logic [ADDR_W-1:0] reg_addr_i,
    input  logic [31:0]       reg_wdata_i,
    output logic              reg_rvalid_o,
    output logic [31:0]       reg_rdata_o,
    output logic              reg_err_o,
    input  logic [NUM_CH-1:0] trace_req_on_i,
    input  logic [NUM_CH-1:0] trace_req_off_i,
    input  logic [NUM_CH-1:0] encapsulator_ready_i,
    output logic [NUM_CH-1:0] trace_enable_o,
    output logic              trace_activated_o,
    output logic              nocontext_o,
    output logic              notime_o,
    output logic              encoder_mode_o,
    output logic              delta_address_o,
    output logic [CFG_W-1:0]  configuration_o
);

    localparam int unsigned     c_WORD_W   = ADDR_W - 2;
    localparam logic [c_WORD_W-1:0] c_W_CTRL   = c_WORD_W'(0);
    localparam logic [c_WORD_W-1:0] c_W_ENABLE = c_WORD_W'(1);
    localparam logic [c_WORD_W-1:0] c_W_EN_SET = c_WORD_W'(2);
    localparam logic [c_WORD_W-1:0] c_W_EN_CLR = c_WORD_W'(3);
    localparam logic [c_WORD_W-1:0] c_W_CNT0   = c_WORD_W'(16);

    logic                          r_activated;
    logic                          r_nocontext;
    logic                          r_notime;
    logic                          r_delta;
    logic [CFG_W-1:0]              r_config;
    logic [NUM_CH-1:0]             r_enable;
    logic [NUM_CH-1:0]             r_prev_ready;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
    logic                          r_rvalid;
    logic [31:0]                   r_rdata;
    logic                          r_err;

    logic [c_WORD_W-1:0] w_word;
    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_force_off;
    logic [NUM_CH-1:0]   w_set_bits;
    logic [NUM_CH-1:0]   w_clr_bits;
    logic [NUM_CH-1:0]   w_cnt_sel;
    logic [NUM_CH-1:0]   w_rise;
    logic [NUM_CH-1:0]   w_fall;
    logic [NUM_CH-1:0]   w_en_next;
    logic [31:0]         w_rdata;
    logic                w_err;
    logic                w_unused;

    assign w_word      = reg_addr_i[ADDR_W-1:2];
    assign w_wr        = reg_req_i & reg_we_i;
    assign w_wr_ctrl   = w_wr && (w_word == c_W_CTRL);
    // Deactivation (current state or being written this cycle) kills every lane.
    assign w_force_off = ~r_activated | (w_wr_ctrl & ~reg_wdata_i[0]);
    assign w_set_bits  = (w_wr && (w_word == c_W_EN_SET)) ? reg_wdata_i[NUM_CH-1:0] : '0;
    assign w_clr_bits  = (w_wr && (w_word == c_W_EN_CLR)) ? reg_wdata_i[NUM_CH-1:0] : '0;
    assign w_rise      = encapsulator_ready_i & ~r_prev_ready;
    assign w_fall      = ~encapsulator_ready_i & r_prev_ready;
    assign w_unused    = ^{reg_addr_i[1:0], reg_wdata_i};

    always_comb begin
        w_en_next = r_enable;
        w_cnt_sel = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_cnt_sel[ch] = (w_word == (c_W_CNT0 + c_WORD_W'(ch)));
            if (w_force_off)
                w_en_next[ch] = 1'b0;
            else if (w_clr_bits[ch])
                w_en_next[ch] = 1'b0;
            else if (trace_req_off_i[ch] | w_fall[ch])
                w_en_next[ch] = 1'b0;
            else if (w_set_bits[ch])
                w_en_next[ch] = 1'b1;
            else if (trace_req_on_i[ch] | w_rise[ch])
                w_en_next[ch] = 1'b1;
        end
    end

    // Read data reflects register state before this cycle's write/events.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        case (w_word)
            c_W_CTRL: begin
                w_rdata[0]         = r_activated;
                w_rdata[1]         = r_nocontext;
                w_rdata[2]         = r_notime;
                w_rdata[3]         = r_delta;
                w_rdata[4+:CFG_W]  = r_config;
            end
            c_W_ENABLE: w_rdata[NUM_CH-1:0] = r_enable;
            c_W_EN_SET,
            c_W_EN_CLR: w_rdata = '0;
            default: begin
                w_err = ~(|w_cnt_sel);
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (w_cnt_sel[ch])
                        w_rdata[CNT_W-1:0] = r_cnt[ch];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_activated  <= 1'b0;
            r_nocontext  <= 1'b1;
            r_notime     <= 1'b1;
            r_delta      <= 1'b1;
            r_config     <= '0;
            r_enable     <= '0;
            r_prev_ready <= '0;
            r_cnt        <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_activated <= reg_wdata_i[0];
                r_nocontext <= reg_wdata_i[1];
                r_notime    <= reg_wdata_i[2];
                r_delta     <= reg_wdata_i[3];
                r_config    <= reg_wdata_i[4+:CFG_W];
            end
            r_enable     <= w_en_next;
            r_prev_ready <= encapsulator_ready_i;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                // A clearing write beats a same-edge increment.
                if (w_wr && w_cnt_sel[ch])
                    r_cnt[ch] <= '0;
                else if (w_en_next[ch] && !r_enable[ch] && (r_cnt[ch] != '1))
                    r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
            end
            r_rvalid <= reg_req_i;
            r_rdata  <= reg_req_i ? w_rdata : '0;
            r_err    <= reg_req_i & w_err;
        end
    end

    assign reg_rvalid_o      = r_rvalid;
    assign reg_rdata_o       = r_rdata;
    assign reg_err_o         = r_err;
    assign trace_enable_o    = r_enable;
    assign trace_activated_o = r_activated;
    assign nocontext_o       = r_nocontext;
    assign notime_o          = r_notime;
    assign encoder_mode_o    = 1'b0;
    assign delta_address_o   = r_delta;
    assign configuration_o   = r_config;

endmodule

`default_nettype wire

// File: tb/tb_trdb_reg_ctrl.sv
// ============================================================================
// Module      : tb_trdb_reg_ctrl
// Description : Directed self-checking bench for trdb_reg_ctrl (2 channels,
//               2-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trdb_reg_ctrl;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned CFG_W  = 2;
    localparam int unsigned ADDR_W = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              reg_req_i = 1'b0;
    logic              reg_we_i = 1'b0;
    logic [ADDR_W-1:0] reg_addr_i = '0;
    logic [31:0]       reg_wdata_i = '0;
    logic              reg_rvalid_o;
    logic [31:0]       reg_rdata_o;
    logic              reg_err_o;
    logic [NUM_CH-1:0] trace_req_on_i = '0;
    logic [NUM_CH-1:0] trace_req_off_i = '0;
    logic [NUM_CH-1:0] encapsulator_ready_i = '0;
    logic [NUM_CH-1:0] trace_enable_o;
    logic              trace_activated_o;
    logic              nocontext_o;
    logic              notime_o;
    logic              encoder_mode_o;
    logic              delta_address_o;
    logic [CFG_W-1:0]  configuration_o;

    int total = 0;
    int bad   = 0;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    trdb_reg_ctrl #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CFG_W(CFG_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_wdata_i(reg_wdata_i), .reg_rvalid_o(reg_rvalid_o),
        .reg_rdata_o(reg_rdata_o), .reg_err_o(reg_err_o),
        .trace_req_on_i(trace_req_on_i), .trace_req_off_i(trace_req_off_i),
        .encapsulator_ready_i(encapsulator_ready_i),
        .trace_enable_o(trace_enable_o), .trace_activated_o(trace_activated_o),
        .nocontext_o(nocontext_o), .notime_o(notime_o),
        .encoder_mode_o(encoder_mode_o), .delta_address_o(delta_address_o),
        .configuration_o(configuration_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock cycle starting and ending at a falling edge; outputs sampled there.
    task automatic step(input logic req, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [1:0] on, input logic [1:0] off);
        reg_req_i       = req;
        reg_we_i        = we;
        reg_addr_i      = addr;
        reg_wdata_i     = wdata;
        trace_req_on_i  = on;
        trace_req_off_i = off;
        @(negedge clk_i);
        rsp_valid       = reg_rvalid_o;
        rsp_data        = reg_rdata_o;
        rsp_err         = reg_err_o;
        reg_req_i       = 1'b0;
        reg_we_i        = 1'b0;
        trace_req_on_i  = '0;
        trace_req_off_i = '0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wdata);
        step(1'b1, 1'b1, addr, wdata, 2'b00, 2'b00);
    endtask

    task automatic rd(input logic [7:0] addr);
        step(1'b1, 1'b0, addr, 32'h0, 2'b00, 2'b00);
    endtask

    task automatic idle(input logic [1:0] on, input logic [1:0] off);
        step(1'b0, 1'b0, 8'h00, 32'h0, on, off);
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle(2'b00, 2'b00);
        idle(2'b00, 2'b00);
        rst_i = 1'b0;
        idle(2'b00, 2'b00);
        total++; if (trace_enable_o !== 2'b00) begin bad++; $display("FAIL reset_enable got=%b want=00", trace_enable_o); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rsp_valid); end
        total++; if ({trace_activated_o, nocontext_o, notime_o, delta_address_o, configuration_o, encoder_mode_o} !== 7'b0111000) begin
            bad++; $display("FAIL reset_ctrl_outs got=%b want=0111000",
                {trace_activated_o, nocontext_o, notime_o, delta_address_o, configuration_o, encoder_mode_o}); end
        rd(8'h00);
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h0000000E}) begin
            bad++; $display("FAIL reset_read_ctrl got=v%b e%b %h want=v1 e0 0000000e", rsp_valid, rsp_err, rsp_data); end
    endtask

    task automatic test_enable_on;
        wr(8'h00, 32'h1);
        total++; if ({trace_activated_o, nocontext_o, notime_o, delta_address_o} !== 4'b1000) begin
            bad++; $display("FAIL ctrl_write got=%b want=1000", {trace_activated_o, nocontext_o, notime_o, delta_address_o}); end
        idle(2'b01, 2'b00);
        total++; if (trace_enable_o !== 2'b01) begin bad++; $display("FAIL on_pulse got=%b want=01", trace_enable_o); end
        rd(8'h40);
        total++; if (rsp_data !== 32'd1) begin bad++; $display("FAIL cnt0_after_on got=%0d want=1", rsp_data); end
        rd(8'h44);
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL cnt1_after_on got=%0d want=0", rsp_data); end
        rd(8'h04);
        total++; if (rsp_data !== 32'd1) begin bad++; $display("FAIL enable_read got=%h want=1", rsp_data); end
    endtask

    task automatic test_priority;
        idle(2'b10, 2'b00);
        total++; if (trace_enable_o !== 2'b11) begin bad++; $display("FAIL ch1_on got=%b want=11", trace_enable_o); end
        idle(2'b10, 2'b10);
        total++; if (trace_enable_o !== 2'b01) begin bad++; $display("FAIL off_beats_on got=%b want=01", trace_enable_o); end
        encapsulator_ready_i = 2'b10;
        idle(2'b00, 2'b00);
        total++; if (trace_enable_o !== 2'b11) begin bad++; $display("FAIL ready_rise got=%b want=11", trace_enable_o); end
        idle(2'b00, 2'b00);
        total++; if (trace_enable_o !== 2'b11) begin bad++; $display("FAIL ready_hold got=%b want=11", trace_enable_o); end
        encapsulator_ready_i = 2'b00;
        idle(2'b00, 2'b00);
        total++; if (trace_enable_o !== 2'b01) begin bad++; $display("FAIL ready_fall got=%b want=01", trace_enable_o); end
        rd(8'h44);
        total++; if (rsp_data !== 32'd2) begin bad++; $display("FAIL cnt1_events got=%0d want=2", rsp_data); end
    endtask

    task automatic test_set_clr;
        wr(8'h08, 32'h3);
        total++; if (trace_enable_o !== 2'b11) begin bad++; $display("FAIL en_set got=%b want=11", trace_enable_o); end
        wr(8'h0C, 32'h1);
        total++; if (trace_enable_o !== 2'b10) begin bad++; $display("FAIL en_clr got=%b want=10", trace_enable_o); end
        wr(8'h08, 32'h1);
        wr(8'h00, 32'h0);
        total++; if ({trace_activated_o, trace_enable_o} !== 3'b000) begin
            bad++; $display("FAIL deactivate got=%b want=000", {trace_activated_o, trace_enable_o}); end
        idle(2'b11, 2'b00);
        encapsulator_ready_i = 2'b11;
        idle(2'b00, 2'b00);
        total++; if (trace_enable_o !== 2'b00) begin bad++; $display("FAIL inactive_ignores_on got=%b want=00", trace_enable_o); end
        encapsulator_ready_i = 2'b00;
        idle(2'b00, 2'b00);
        wr(8'h00, 32'h1);
        total++; if (trace_enable_o !== 2'b00) begin bad++; $display("FAIL reactivate got=%b want=00", trace_enable_o); end
        step(1'b1, 1'b0, 8'h04, 32'h0, 2'b01, 2'b00);
        total++; if ({rsp_data, trace_enable_o} !== {32'h0, 2'b01}) begin
            bad++; $display("FAIL enable_read_pre_event got=%h/%b want=0/01", rsp_data, trace_enable_o); end
        rd(8'h40);
        total++; if (rsp_data !== 32'd3) begin bad++; $display("FAIL cnt0_three got=%0d want=3", rsp_data); end
        wr(8'h00, 32'h31);
        rd(8'h00);
        total++; if ({rsp_data, configuration_o, trace_enable_o} !== {32'h31, 2'b11, 2'b01}) begin
            bad++; $display("FAIL ctrl_config got=%h/%b/%b want=31/11/01", rsp_data, configuration_o, trace_enable_o); end
    endtask

    task automatic test_counter_sat;
        wr(8'h40, 32'h0);
        rd(8'h40);
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL cnt0_clear got=%0d want=0", rsp_data); end
        for (int i = 0; i < 5; i++) begin
            wr(8'h0C, 32'h1);
            idle(2'b01, 2'b00);
        end
        rd(8'h40);
        total++; if ({rsp_data, trace_enable_o[0]} !== {32'd3, 1'b1}) begin
            bad++; $display("FAIL cnt0_saturate got=%0d/%b want=3/1", rsp_data, trace_enable_o[0]); end
        wr(8'h0C, 32'h1);
        step(1'b1, 1'b1, 8'h40, 32'h0, 2'b01, 2'b00);
        rd(8'h40);
        total++; if ({rsp_data, trace_enable_o[0]} !== {32'd0, 1'b1}) begin
            bad++; $display("FAIL cnt0_clear_wins got=%0d/%b want=0/1", rsp_data, trace_enable_o[0]); end
    endtask

    task automatic test_back_to_back;
        wr(8'h0C, 32'h3);
        total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL b2b_first got=%b want=10", {rsp_valid, rsp_err}); end
        rd(8'h04);
        total++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL b2b_second got=v%b %h want=v1 0", rsp_valid, rsp_data); end
    endtask

    task automatic test_unmapped;
        rd(8'h20);
        total++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL unmapped_read got=v%b e%b %h want=v1 e1 0", rsp_valid, rsp_err, rsp_data); end
        wr(8'h20, 32'hFFFF_FFFF);
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL unmapped_write_err got=%b want=1", rsp_err); end
        rd(8'h00);
        total++; if ({rsp_err, rsp_data} !== {1'b0, 32'h31}) begin
            bad++; $display("FAIL unmapped_no_effect got=e%b %h want=e0 31", rsp_err, rsp_data); end
        total++; if (trace_enable_o !== 2'b00) begin bad++; $display("FAIL unmapped_enable got=%b want=00", trace_enable_o); end
        rd(8'h08);
        total++; if ({rsp_err, rsp_data} !== {1'b0, 32'h0}) begin
            bad++; $display("FAIL wo_read got=e%b %h want=e0 0", rsp_err, rsp_data); end
        rd(8'h48);
        total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL cnt_out_of_range got=%b want=1", rsp_err); end
    endtask

    task automatic test_reset_mid;
        rst_i = 1'b1;
        rd(8'h00);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_drops_rsp got=%b want=0", rsp_valid); end
        rst_i = 1'b0;
        rd(8'h00);
        total++; if (rsp_data !== 32'h0000000E) begin bad++; $display("FAIL reset_ctrl_again got=%h want=0000000e", rsp_data); end
        rd(8'h44);
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_cnt1 got=%0d want=0", rsp_data); end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset;
        test_enable_on;
        test_priority;
        test_set_clr;
        test_counter_sat;
        test_back_to_back;
        test_unmapped;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
